// File: rtl/bsg_arb_round_robin_hold_if.sv
// Requester/resource-side signals of the round-robin hold arbiter.
// The arbiter connects through the slave modport; the master modport is the requester/resource side.
interface bsg_arb_round_robin_hold_if #(
  parameter int unsigned inputs_p = 8
);
  localparam int unsigned lg_inputs_lp = $clog2(inputs_p);

  logic [inputs_p-1:0]     reqs_i;
  logic [inputs_p-1:0]     last_i;
  logic                    ready_i;
  logic [inputs_p-1:0]     grants_o;
  logic                    v_o;
  logic [lg_inputs_lp-1:0] sel_id_o;
  logic                    lock_o;

  modport master (
    output reqs_i, last_i, ready_i,
    input  grants_o, v_o, sel_id_o, lock_o
  );

  modport slave (
    input  reqs_i, last_i, ready_i,
    output grants_o, v_o, sel_id_o, lock_o
  );
endinterface

// File: rtl/bsg_arb_round_robin_hold.sv
// Round-robin arbiter that holds the grant on one requester until it sends a last beat,
// then rotates priority to the requester just above the winner.
module bsg_arb_round_robin_hold #(
  parameter int unsigned inputs_p = 8
) (
  input logic                        clk_i,
  input logic                        reset_n_i,
  bsg_arb_round_robin_hold_if.slave  bus
);
  localparam int unsigned lg_inputs_lp = $clog2(inputs_p);

  typedef enum logic {IDLE, LOCKED} mode_e;

  mode_e                   mode_r;
  logic [lg_inputs_lp-1:0] lock_id_r;
  logic [lg_inputs_lp-1:0] last_winner_r;
  logic                    lock_r;

  logic                    cand_found;
  logic [lg_inputs_lp-1:0] cand_id;
  logic [inputs_p-1:0]     grants;
  logic [lg_inputs_lp-1:0] sel_id;
  logic                    xfer;
  logic                    xfer_last;

  // Circular search starting one above the previous winner
  always_comb begin
    cand_found = 1'b0;
    cand_id    = '0;
    for (int unsigned i = 1; i <= inputs_p; i++) begin
      int unsigned idx;
      idx = (int'(last_winner_r) + i) % inputs_p;
      if (!cand_found && bus.reqs_i[idx]) begin
        cand_found = 1'b1;
        cand_id    = lg_inputs_lp'(idx);
      end
    end
  end

  // Grant is combinational and forced off while reset is asserted
  always_comb begin
    grants = '0;
    sel_id = '0;
    if (reset_n_i && bus.ready_i) begin
      if (mode_r == IDLE) begin
        if (cand_found) begin
          grants = inputs_p'(1) << cand_id;
          sel_id = cand_id;
        end
      end else if (bus.reqs_i[lock_id_r]) begin
        grants = inputs_p'(1) << lock_id_r;
        sel_id = lock_id_r;
      end
    end
  end

  assign xfer      = |grants;
  assign xfer_last = bus.last_i[sel_id];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mode_r        <= IDLE;
      lock_id_r     <= '0;
      last_winner_r <= lg_inputs_lp'(inputs_p - 1);
      lock_r        <= 1'b0;
    end else if (xfer) begin
      case (mode_r)
        IDLE: begin
          if (xfer_last) begin
            last_winner_r <= sel_id;
          end else begin
            mode_r    <= LOCKED;
            lock_id_r <= sel_id;
            lock_r    <= 1'b1;
          end
        end
        LOCKED: begin
          if (xfer_last) begin
            mode_r        <= IDLE;
            last_winner_r <= lock_id_r;
            lock_r        <= 1'b0;
          end
        end
        default: mode_r <= IDLE;
      endcase
    end
  end

  assign bus.grants_o = grants;
  assign bus.v_o      = xfer;
  assign bus.sel_id_o = sel_id;
  assign bus.lock_o   = lock_r;
endmodule

// File: doc/bsg_arb_round_robin_hold.md
Name: bsg_arb_round_robin_hold

Overview:
Round-robin arbiter that shares one downstream resource (a single-port link or FIFO enqueue) between inputs_p requesters. It is the fair, multi-beat companion to the fixed lo-to-hi priority arbiter. A winner keeps the grant, and the resource stays locked to it, until that requester presents a beat flagged last. Priority then rotates to the requester just above the winner.

Parameters:
inputs_p, 8, number of requesters; at least 2.
lg_inputs_lp, $clog2(inputs_p), derived; width of the winner index.

Ports:
clk_i  input  1  clock.
reset_n_i  input  1  asynchronous, active-low reset.
reqs_i  input  inputs_p  per-requester beat-valid; bit k means requester k has a beat this cycle.
last_i  input  inputs_p  per-requester last-beat flag; qualified only by the granted beat.
ready_i  input  1  the shared resource accepts a beat this cycle.
grants_o  output  inputs_p  one-hot grant; a beat transfers when its bit is 1 (already includes ready_i).
v_o  output  1  equals |grants_o.
sel_id_o  output  lg_inputs_lp  binary index of the granted requester; 0 when v_o=0.
lock_o  output  1  registered; 1 while mid-packet and locked to one requester.

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-low (reset_n_i).
- State:
  - mode: IDLE or LOCKED.
  - lock_id_r: lg_inputs_lp bits.
  - last_winner_r: lg_inputs_lp bits.
- Reset (reset_n_i=0, takes effect immediately with no clock): mode=IDLE, lock_id_r=0, last_winner_r=inputs_p-1, lock_o=0.
- While reset_n_i=0: grants_o=0, v_o=0, sel_id_o=0. Reset asserted mid-packet drops the lock; the first grant after reset goes to the lowest-index requester.
- IDLE, combinational, zero latency:
  - Search reqs_i circularly starting at (last_winner_r+1) mod inputs_p; the first set bit is the candidate.
  - grants_o = onehot(candidate) & {inputs_p{ready_i}}.
  - No requests, or ready_i=0: grants_o=0.
- IDLE transitions, at the clock edge when a beat transfers:
  - last_i[cand]=1 (single-beat packet): stay IDLE; last_winner_r<=cand.
  - last_i[cand]=0: go to LOCKED; lock_id_r<=cand; lock_o<=1. last_winner_r is unchanged.
  - No transfer: no state change. The candidate is not latched, so a higher-priority request arriving while ready_i=0 may take the grant.
- LOCKED:
  - grants_o = onehot(lock_id_r) & reqs_i[lock_id_r] & ready_i.
  - All other requesters are ignored, even if the locked requester bubbles (reqs_i[lock_id_r]=0).
  - Transfer with last_i[lock_id_r]=1: go to IDLE; last_winner_r<=lock_id_r; lock_o<=0. The next IDLE cycle arbitrates fresh; there is no dead cycle.
  - Transfer without last: stay LOCKED.
- Wrap-around: when last_winner_r=inputs_p-1, the search starts at 0.
- last_i on ungranted requesters has no effect.
- A requester that withdraws reqs_i before being granted is simply skipped; no state is recorded.
- Invariants (bench asserts these):
  - grants_o is one-hot or zero.
  - ready_i=0 implies grants_o=0.
  - In LOCKED, grants_o & ~onehot(lock_id_r) = 0.
  - sel_id_o is consistent with grants_o.
- Fairness: with all requesters continuously requesting single-beat packets, each requester is granted exactly once per inputs_p consecutive transfers.
- No combinational path from grants_o back into any input is assumed.

Test Plan:
1. Reset then idle: reset_n_i pulsed low, reqs_i=0 -> grants_o=0, lock_o=0. Then reqs_i=8'hFF, last_i=8'hFF, ready_i=1 for 10 cycles -> grant order 0,1,…,7,0,1.
2. Packet lock: reqs_i=8'h09, last_i=0, ready_i=1, requester 0 sends 3 beats with last on beat 3. Expected response:
   - grants_o=8'h01 for 3 cycles, lock_o=1 after beat 1.
   - Cycle 4: grants_o=8'h08, sel_id_o=3.
3. Backpressure and bubble in LOCKED:
   - Locked to 2, ready_i=0 for 2 cycles -> grants_o=0, lock_o stays 1.
   - Then reqs_i[2]=0 with reqs_i[5]=1 and ready_i=1 -> grants_o=0; requester 5 is not granted until requester 2 sends its last beat.
4. Wrap-around: last_winner_r=7, reqs_i=8'h81 -> grant 0. Next cycle with reqs_i=8'h80 -> grant 7.
5. Mid-packet reset: locked to 4 after 2 beats, reset_n_i driven low between clock edges -> lock_o=0 and grants_o=0 immediately. After release, reqs_i=8'h12 -> grant bit 1 (8'h02).
6. Idle retarget: ready_i=0 with reqs_i=8'h40, then reqs_i=8'h42 with ready_i=1 and last_winner_r=0 -> grants_o=8'h02.
